// File: rtl/csel_addsub_pipe.sv
// Pipelined WIDTH-bit add/subtract: one carry-select slice of BLOCK bits per stage,
// valid/ready handshake with whole-pipeline stall, tag and signed-overflow sideband.

module csel_slice #(
  parameter int BLOCK = 16,
  parameter int SEG   = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co
);
  localparam int NSEG = BLOCK / SEG;

  // Both carry-in outcomes per segment; {carry, sum} packed in each entry.
  logic [SEG:0] r0 [NSEG];
  logic [SEG:0] r1 [NSEG];
  logic         cy;

  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    assign r0[g] = {1'b0, a[g*SEG +: SEG]} + {1'b0, b[g*SEG +: SEG]};
    assign r1[g] = {1'b0, a[g*SEG +: SEG]} + {1'b0, b[g*SEG +: SEG]} + (SEG+1)'(1);
  end

  always_comb begin
    s  = '0;
    cy = ci;
    for (int g = 0; g < NSEG; g++) begin
      s[g*SEG +: SEG] = cy ? r1[g][SEG-1:0] : r0[g][SEG-1:0];
      cy              = cy ? r1[g][SEG]     : r0[g][SEG];
    end
    co = cy;
  end
endmodule

module csel_addsub_pipe #(
  parameter int WIDTH = 64,
  parameter int BLOCK = 16,
  parameter int SEG   = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] tag_out
);
  localparam int STAGES = WIDTH / BLOCK;

  if ((WIDTH % BLOCK) != 0 || (BLOCK % SEG) != 0) begin : g_cfg_err
    $error("csel_addsub_pipe: WIDTH must be a multiple of BLOCK and BLOCK of SEG");
  end

  // Register j: res_p holds operand A rotated right by j slices, with the finished
  // sum slices filling in from the top, so the current slice always sits at bit 0.
  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0][WIDTH-1:0] res_p;
  logic [STAGES:0]            c_p;
  logic [STAGES:0][TAG_W-1:0] tag_p;
  logic                       ovf_q;

  logic [WIDTH-1:0] nxt_res [STAGES];
  logic             nxt_c   [STAGES];
  logic             nxt_ovf;
  logic             adv;

  assign adv      = ~(vld_pipe[STAGES] & ~out_ready);
  assign in_ready = adv;

  // Remaining B slices shrink by one slice per stage, right-aligned.
  for (genvar j = 0; j < STAGES; j++) begin : g_b
    logic [WIDTH-j*BLOCK-1:0] r;
    if (j == 0) begin : g_ld
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                  r <= '0;
        else if (adv && in_valid)    r <= sub ? ~b : b;
    end else begin : g_ld
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                  r <= '0;
        else if (adv && vld_pipe[j-1]) r <= g_b[j-1].r[WIDTH-(j-1)*BLOCK-1:BLOCK];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [BLOCK-1:0] s_k;
    logic             co_k;

    csel_slice #(.BLOCK(BLOCK), .SEG(SEG)) u_slice (
      .a  (res_p[k][BLOCK-1:0]),
      .b  (g_b[k].r[BLOCK-1:0]),
      .ci (c_p[k]),
      .s  (s_k),
      .co (co_k)
    );

    assign nxt_res[k] = (res_p[k] >> BLOCK) | (WIDTH'(s_k) << (WIDTH - BLOCK));
    assign nxt_c[k]   = co_k;

    // Carry into the MSB recovered from its sum bit and operand bits.
    if (k == STAGES-1) begin : g_ovf
      assign nxt_ovf = s_k[BLOCK-1] ^ res_p[k][BLOCK-1] ^ g_b[k].r[BLOCK-1] ^ co_k;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      res_p    <= '0;
      c_p      <= '0;
      tag_p    <= '0;
      ovf_q    <= 1'b0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
      if (in_valid) begin
        res_p[0] <= a;
        c_p[0]   <= sub | cin;
        tag_p[0] <= tag_in;
      end
      // Bubbles move on without touching data so outputs keep their last value.
      for (int k = 0; k < STAGES; k++) begin
        if (vld_pipe[k]) begin
          res_p[k+1] <= nxt_res[k];
          c_p[k+1]   <= nxt_c[k];
          tag_p[k+1] <= tag_p[k];
        end
      end
      if (vld_pipe[STAGES-1]) ovf_q <= nxt_ovf;
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign sum       = res_p[STAGES];
  assign cout      = c_p[STAGES];
  assign ovf       = ovf_q;
  assign tag_out   = tag_p[STAGES];
endmodule

// File: tb/tb_csel_addsub_pipe.sv
// Directed + random bench for csel_addsub_pipe at default parameters; a queue
// scoreboard holds expected results from accept until the beat retires.

module tb_csel_addsub_pipe;
  localparam int W = 64;
  localparam int T = 4;
  localparam int S = 4;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready;
  logic [W-1:0] a = '0, b = '0, sum;
  logic         cin = 1'b0, sub = 1'b0;
  logic [T-1:0] tag_in = '0, tag_out;
  logic         out_valid, out_ready = 1'b1, cout, ovf;

  always #5 clk = ~clk;

  csel_addsub_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .ovf(ovf), .tag_out(tag_out)
  );

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    logic [T-1:0] t;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_cmp = 0, n_bad = 0, n_ret = 0;

  function automatic exp_t model(input logic [W-1:0] aa, bb, input logic ci, sb,
                                 input logic [T-1:0] tg);
    exp_t         r;
    logic [W-1:0] be;
    logic [W:0]   full;
    be   = sb ? ~bb : bb;
    full = {1'b0, aa} + {1'b0, be} + (W+1)'(sb ? 1'b1 : ci);
    r.s  = full[W-1:0];
    r.c  = full[W];
    r.o  = (aa[W-1] == be[W-1]) && (full[W-1] != aa[W-1]);
    r.t  = tg;
    return r;
  endfunction

  task automatic check(input string nm, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accept, pop and compare on retire (sampled mid-cycle).
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("spurious_out", 1, 0);
        else begin
          e = q.pop_front();
          check("sum",  sum,     e.s);
          check("cout", cout,    e.c);
          check("ovf",  ovf,     e.o);
          check("tag",  tag_out, e.t);
        end
        n_ret++;
      end
      if (in_valid && in_ready) q.push_back(model(a, b, cin, sub, tag_in));
    end
  end

  task automatic send(input logic [W-1:0] aa, bb, input logic ci, sb, input logic [T-1:0] tg);
    int guard = 0;
    a = aa; b = bb; cin = ci; sub = sb; tag_in = tg; in_valid = 1'b1;
    #1;
    while (!in_ready && guard < 100) begin tick(); guard++; end
    if (!in_ready) check("send_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() != 0 && guard < 300) begin tick(); guard++; end
    check("drain_empty", W'(q.size()), 0);
  endtask

  task automatic lat_test(input logic [W-1:0] aa, bb, input logic ci, sb,
                          input logic [T-1:0] tg, input logic [W-1:0] es);
    a = aa; b = bb; cin = ci; sub = sb; tag_in = tg; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("lat_accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= S; i++) begin
      tick();
      check("latency_valid", out_valid, (i == S));
    end
    check("lat_sum", sum, es);
    check("lat_tag", tag_out, tg);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] held;
    int acc, base;
    logic took;

    // Reset state
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum",       sum,       0);
    check("rst_cout",      cout,      0);
    check("rst_ovf",       ovf,       0);
    check("rst_tag",       tag_out,   0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    tick();

    // Basic add with exact latency
    lat_test(64'd5000, 64'd6125, 1'b0, 1'b0, 4'd3, 64'd11125);
    check("add_cout", cout, 0);
    check("add_ovf",  ovf,  0);

    // Carry rippling through every stage, then signed overflow
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 4'd1);
    drain();
    check("carry_sum",  sum,  64'd0);
    check("carry_cout", cout, 1);
    check("carry_ovf",  ovf,  0);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 4'd2);
    drain();
    check("ovf_sum",  sum,  64'h8000_0000_0000_0000);
    check("ovf_cout", cout, 0);
    check("ovf_ovf",  ovf,  1);

    // Subtract with and without borrow; cin ignored
    send(64'd88000, 64'd100000, 1'b1, 1'b1, 4'd4);
    drain();
    check("sub_borrow_sum",  sum,  64'hFFFF_FFFF_FFFF_D120);
    check("sub_borrow_cout", cout, 0);
    send(64'd100000, 64'd88000, 1'b0, 1'b1, 4'd5);
    drain();
    check("sub_sum",  sum,  64'd12000);
    check("sub_cout", cout, 1);

    // Streaming 8 beats with a 4-cycle downstream stall
    acc  = 0;
    base = n_ret;
    for (int c = 0; c < 80 && (acc < 8 || q.size() != 0); c++) begin
      out_ready = !(c >= 6 && c <= 9);
      in_valid  = (acc < 8);
      a      = {$urandom, $urandom};
      b      = {$urandom, $urandom};
      cin    = 1'($urandom);
      sub    = 1'($urandom);
      tag_in = T'(acc);
      #1;
      if (c >= 6 && c <= 9) check("stall_in_ready", in_ready, 0);
      if (c == 6) held = sum;
      if (c >= 7 && c <= 9) check("stall_sum_stable", sum, held);
      took = in_valid && in_ready;
      tick();
      if (took) acc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    check("stream_count", W'(n_ret - base), 8);

    // Asynchronous reset with beats in flight
    send(64'd11, 64'd22, 1'b0, 1'b0, 4'd9);
    send(64'd33, 64'd44, 1'b0, 1'b0, 4'd10);
    send(64'd55, 64'd66, 1'b0, 1'b0, 4'd11);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum",       sum,       0);
    q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    base = n_ret;
    for (int i = 0; i < 8; i++) tick();
    check("midrst_no_output", W'(n_ret - base), 0);
    lat_test(64'd1234, 64'd4321, 1'b1, 1'b0, 4'd6, 64'd5556);

    // Random traffic with random backpressure
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      a   = ($urandom_range(7) == 0) ? '1 : {$urandom, $urandom};
      b   = ($urandom_range(7) == 0) ? '1 : {$urandom, $urandom};
      cin = 1'($urandom);
      sub = 1'($urandom);
      tag_in = T'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
